// File: rtl/multi_adc_sampler.sv
// multi_adc_sampler: drives one shared CS/SCLK pair to pADC_NUM serial ADCs,
// deserialises their data lines in parallel and emits one word per ADC per
// conversion towards per-ADC FIFOs, for bursts of iSAMPLES conversions.
module multi_adc_sampler #(
  parameter int unsigned pADC_NUM     = 5,
  parameter int unsigned pDATA_W      = 16,
  parameter logic [7:0]  pACTIVE_EDGE = "F",
  parameter int unsigned pCS_HIGH     = 3
) (
  input  logic                         iCLK,
  input  logic                         iRST,
  input  logic                         iEN,
  input  logic                         iSTART,
  input  logic [15:0]                  iSAMPLES,
  input  logic [15:0]                  iCLK_DIV,
  input  logic [15:0]                  iCLK_DUTY,
  output logic                         oBUSY,
  output logic                         oCOMPL,
  output logic                         oERROR,
  output logic                         oCS,
  output logic                         oSCLK,
  input  logic [pADC_NUM-1:0]          iSDATA,
  input  logic [pADC_NUM-1:0]          iFULL,
  output logic [pADC_NUM-1:0]          oWR,
  output logic [pADC_NUM*pDATA_W-1:0]  oDATA
);

  localparam int unsigned BIT_W     = (pDATA_W > 1) ? $clog2(pDATA_W) : 1;
  localparam int unsigned GAP_W     = (pCS_HIGH > 1) ? $clog2(pCS_HIGH) : 1;
  localparam bit          RISE_CAPT = (pACTIVE_EDGE == "R");

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_GAP, S_DONE} state_t;

  state_t                                  state_q, state_d;
  logic [15:0]                             phase_q, phase_d;
  logic [BIT_W-1:0]                        bit_q, bit_d;
  logic [GAP_W-1:0]                        gap_q, gap_d;
  logic [15:0]                             words_q, words_d;
  logic [15:0]                             nsamp_q, nsamp_d;
  logic [15:0]                             div_q, div_d;
  logic [15:0]                             duty_q, duty_d;
  logic [pADC_NUM-1:0][pDATA_W-1:0]        shift_q, shift_d;

  logic                                    busy_q, busy_d;
  logic                                    compl_q, compl_d;
  logic                                    err_q, err_d;
  logic                                    cs_q, cs_d;
  logic                                    sclk_q, sclk_d;
  logic [pADC_NUM-1:0]                     wr_q, wr_d;
  logic [pADC_NUM*pDATA_W-1:0]             data_q, data_d;

  logic [15:0]                             div_in;
  logic [15:0]                             duty_in;
  logic                                    capture;

  // Next-state, counters, capture and registered-output decode
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    words_d = words_q;
    nsamp_d = nsamp_q;
    div_d   = div_q;
    duty_d  = duty_q;
    shift_d = shift_q;
    err_d   = err_q;
    wr_d    = '0;
    data_d  = data_q;
    capture = 1'b0;

    // Sanitised clock shape from the raw config inputs
    div_in = (iCLK_DIV < 16'd2) ? 16'd2 : iCLK_DIV;
    if (iCLK_DUTY == 16'd0) begin
      duty_in = 16'd1;
    end else if (iCLK_DUTY > div_in - 16'd1) begin
      duty_in = div_in - 16'd1;
    end else begin
      duty_in = iCLK_DUTY;
    end

    case (state_q)
      S_IDLE: begin
        if (iEN && iSTART) begin
          div_d   = div_in;
          duty_d  = duty_in;
          nsamp_d = iSAMPLES;
          words_d = 16'd0;
          phase_d = 16'd0;
          bit_d   = '0;
          err_d   = 1'b0;
          state_d = (iSAMPLES == 16'd0) ? S_DONE : S_CONV;
        end
      end

      S_CONV: begin
        // Falling-edge capture sits at the first low phase; rising-edge
        // capture at the last phase, just before SCLK returns high.
        capture = RISE_CAPT ? (phase_q == div_q - 16'd1) : (phase_q == duty_q);
        if (capture) begin
          for (int a = 0; a < int'(pADC_NUM); a++) begin
            shift_d[a] = {shift_q[a][pDATA_W-2:0], iSDATA[a]};
          end
        end
        if (phase_q == div_q - 16'd1) begin
          phase_d = 16'd0;
          if (bit_q == BIT_W'(pDATA_W - 1)) begin
            // Last bit done: hand the word to every FIFO that can take it
            bit_d   = '0;
            gap_d   = '0;
            state_d = S_GAP;
            wr_d    = ~iFULL;
            data_d  = shift_d;
            words_d = words_q + 16'd1;
            if (|iFULL) begin
              err_d = 1'b1;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end

      S_GAP: begin
        if (gap_q == GAP_W'(pCS_HIGH - 1)) begin
          if ((words_q == nsamp_q) || !iEN) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CONV;
            phase_d = 16'd0;
            bit_d   = '0;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they appear registered
    cs_d    = (state_d != S_CONV);
    sclk_d  = (state_d == S_CONV) ? (phase_d < duty_d) : 1'b1;
    busy_d  = (state_d == S_CONV) || (state_d == S_GAP);
    compl_d = (state_d == S_DONE);
  end

  // Control state and registered outputs; reset restores the idle bus
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_IDLE;
      phase_q <= 16'd0;
      bit_q   <= '0;
      gap_q   <= '0;
      words_q <= 16'd0;
      busy_q  <= 1'b0;
      compl_q <= 1'b0;
      err_q   <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      wr_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      words_q <= words_d;
      busy_q  <= busy_d;
      compl_q <= compl_d;
      err_q   <= err_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
    end
  end

  // Latched burst configuration and deserialisers; contents are only
  // meaningful inside a burst, so they carry no reset
  always_ff @(posedge iCLK) begin
    nsamp_q <= nsamp_d;
    div_q   <= div_d;
    duty_q  <= duty_d;
    shift_q <= shift_d;
  end

  assign oBUSY  = busy_q;
  assign oCOMPL = compl_q;
  assign oERROR = err_q;
  assign oCS    = cs_q;
  assign oSCLK  = sclk_q;
  assign oWR    = wr_q;
  assign oDATA  = data_q;

endmodule

// File: tb/tb_multi_adc_sampler.sv
// Bench for multi_adc_sampler: a falling-edge and a rising-edge instance run
// the same directed bursts, each fed by its own serial ADC model, and both are
// compared every cycle against one timing-formula model of the burst.
`timescale 1ns/1ps
module tb_multi_adc_sampler;
  localparam int NA  = 5;
  localparam int W   = 16;
  localparam int CSH = 3;

  typedef enum int {M_IDLE, M_RUN, M_DONE} mmode_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, en, start;
  logic [15:0]       samples, cdiv, cduty, base;
  logic [NA-1:0]     full;
  logic [NA-1:0]     sdata [2];
  logic              busy [2];
  logic              compl [2];
  logic              err [2];
  logic              cs [2];
  logic              sclk [2];
  logic [NA-1:0]     wr [2];
  logic [NA*W-1:0]   data [2];

  int checks = 0;
  int errors = 0;
  int rel    = 0;
  int wrcnt  = 0;

  multi_adc_sampler #(.pADC_NUM(NA), .pDATA_W(W), .pACTIVE_EDGE("F"), .pCS_HIGH(CSH)) u_dut_f (
    .iCLK(clk), .iRST(rst), .iEN(en), .iSTART(start), .iSAMPLES(samples),
    .iCLK_DIV(cdiv), .iCLK_DUTY(cduty), .oBUSY(busy[0]), .oCOMPL(compl[0]),
    .oERROR(err[0]), .oCS(cs[0]), .oSCLK(sclk[0]), .iSDATA(sdata[0]),
    .iFULL(full), .oWR(wr[0]), .oDATA(data[0]));

  multi_adc_sampler #(.pADC_NUM(NA), .pDATA_W(W), .pACTIVE_EDGE("R"), .pCS_HIGH(CSH)) u_dut_r (
    .iCLK(clk), .iRST(rst), .iEN(en), .iSTART(start), .iSAMPLES(samples),
    .iCLK_DIV(cdiv), .iCLK_DUTY(cduty), .oBUSY(busy[1]), .oCOMPL(compl[1]),
    .oERROR(err[1]), .oCS(cs[1]), .oSCLK(sclk[1]), .iSDATA(sdata[1]),
    .iFULL(full), .oWR(wr[1]), .oDATA(data[1]));

  // Word that ADC a sends in conversion k of a burst
  function automatic logic [15:0] adc_word(input logic [15:0] b, input int a, input int k);
    return b + 16'(a) + 16'(k << 12);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] get_sig(input int d, input int sel);
    case (sel)
      0:       return 128'(busy[d]);
      1:       return 128'(compl[d]);
      2:       return 128'(err[d]);
      3:       return 128'(cs[d]);
      4:       return 128'(sclk[d]);
      5:       return 128'(wr[d]);
      default: return 128'(data[d]);
    endcase
  endfunction

  task automatic chk_both(input string nm, input int sel, input logic [127:0] exp);
    for (int d = 0; d < 2; d++) chk($sformatf("%s_d%0d", nm, d), get_sig(d, sel), exp);
  endtask

  task automatic chk_reset_state(input string nm);
    chk_both({nm, "_busy"}, 0, 0);
    chk_both({nm, "_compl"}, 1, 0);
    chk_both({nm, "_err"}, 2, 0);
    chk_both({nm, "_cs"}, 3, 1);
    chk_both({nm, "_sclk"}, 4, 1);
    chk_both({nm, "_wr"}, 5, 0);
    chk_both({nm, "_data"}, 6, 0);
  endtask

  // ---------------- behavioural model ----------------
  mmode_t          m_mode = M_IDLE;
  int              m_t = 0, m_n = 0, m_div = 2, m_duty = 1, m_words = 0;
  logic [15:0]     m_base = '0;
  logic            e_busy = 0, e_compl = 0, e_err = 0, e_cs = 1, e_sclk = 1;
  logic [NA-1:0]   e_wr = '0;
  logic [NA*W-1:0] e_data = '0;

  initial begin
    int p, k, ph;
    forever begin
      @(posedge clk);
      e_wr = '0;
      if (rst) begin
        m_mode = M_IDLE;
        e_err  = 1'b0;
        e_data = '0;
      end else begin
        case (m_mode)
          M_IDLE: if (en && start) begin
            m_div  = (cdiv < 2) ? 2 : int'(cdiv);
            m_duty = (cduty < 1) ? 1 : ((int'(cduty) > m_div - 1) ? m_div - 1 : int'(cduty));
            m_n    = int'(samples);
            m_base = base;
            m_words = 0;
            m_t    = 0;
            e_err  = 1'b0;
            m_mode = (samples == 0) ? M_DONE : M_RUN;
          end
          M_DONE: m_mode = M_IDLE;
          default: begin
            p = W * m_div + CSH;
            m_t++;
            if ((m_t % p) == W * m_div) begin
              k = m_t / p;
              e_wr = ~full;
              for (int a = 0; a < NA; a++) e_data[a*W +: W] = adc_word(m_base, a, k);
              if (|full) e_err = 1'b1;
              m_words = k + 1;
            end
            if ((m_t % p) == 0 && (m_words == m_n || !en)) m_mode = M_DONE;
          end
        endcase
      end
      p  = W * m_div + CSH;
      ph = m_t % p;
      e_busy  = (m_mode == M_RUN);
      e_compl = (m_mode == M_DONE);
      if (m_mode == M_RUN && ph < W * m_div) begin
        e_cs   = 1'b0;
        e_sclk = ((ph % m_div) < m_duty);
      end else begin
        e_cs   = 1'b1;
        e_sclk = 1'b1;
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("d%0d_busy", d),  128'(busy[d]),  128'(e_busy));
        chk($sformatf("d%0d_compl", d), 128'(compl[d]), 128'(e_compl));
        chk($sformatf("d%0d_err", d),   128'(err[d]),   128'(e_err));
        chk($sformatf("d%0d_cs", d),    128'(cs[d]),    128'(e_cs));
        chk($sformatf("d%0d_sclk", d),  128'(sclk[d]),  128'(e_sclk));
        chk($sformatf("d%0d_wr", d),    128'(wr[d]),    128'(e_wr));
        chk($sformatf("d%0d_data", d),  128'(data[d]),  128'(e_data));
      end
      if (wr[0] != '0) wrcnt++;
    end
  end

  // Serial ADC models: the "F" instance sees data change on SCLK rise, the
  // "R" instance sees data change on SCLK fall (first bit valid from CS fall).
  // Also counts SCLK falls and CS-low cycles per conversion window.
  initial begin
    int a_rise [2], a_fall [2], a_k [2], a_low [2], idx;
    logic a_psclk [2], a_pcs [2];
    logic [15:0] wd;
    for (int d = 0; d < 2; d++) begin
      a_rise[d] = 0; a_fall[d] = 0; a_k[d] = 0; a_low[d] = 0;
      a_psclk[d] = 1'b1; a_pcs[d] = 1'b1;
      sdata[d] = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (m_mode != M_RUN) a_k[d] = 0;
        else if (!a_pcs[d] && cs[d]) a_k[d]++;
        if (!a_pcs[d] && cs[d] && m_mode == M_RUN) begin
          chk($sformatf("sclk_falls_d%0d", d), 128'(a_fall[d]), 128'(W));
          chk($sformatf("cs_low_len_d%0d", d), 128'(a_low[d]), 128'(W * m_div));
        end
        if (cs[d]) begin
          a_rise[d] = 0; a_fall[d] = 0; a_low[d] = 0; a_psclk[d] = 1'b1;
        end else begin
          a_low[d]++;
          if (!a_psclk[d] && sclk[d]) a_rise[d]++;
          if (a_psclk[d] && !sclk[d]) a_fall[d]++;
          a_psclk[d] = sclk[d];
        end
        a_pcs[d] = cs[d];
        idx = (d == 0) ? a_rise[d] : ((a_fall[d] > 0) ? a_fall[d] - 1 : 0);
        for (int a = 0; a < NA; a++) begin
          wd = adc_word(m_base, a, a_k[d]);
          sdata[d][a] = (idx < W) ? wd[W-1-idx] : 1'b0;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic start_burst(input logic [15:0] n, input logic [15:0] dv,
                             input logic [15:0] dt, input logic [15:0] b, input bit hold);
    samples = n; cdiv = dv; cduty = dt; base = b; en = 1'b1; start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    rel = 0;
  endtask

  task automatic at_rel(input int r);
    while (rel < r) begin
      @(negedge clk);
      rel++;
    end
  endtask

  initial begin
    int snap;
    rst = 1'b1; en = 1'b0; start = 1'b0; samples = '0; cdiv = 16'd4;
    cduty = 16'd2; full = '0; base = 16'hA5A0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    // Two words, falling-style shape div=4 duty=2
    start_burst(16'd2, 16'd4, 16'd2, 16'hA5A0, 1'b0);
    chk_both("t1_cs_t0", 3, 0);
    chk_both("t1_busy_t0", 0, 1);
    chk_both("t1_sclk_t0", 4, 1);
    at_rel(64);
    chk_both("t1_wr0", 5, 5'h1F);
    chk_both("t1_data0", 6, {16'hA5A4, 16'hA5A3, 16'hA5A2, 16'hA5A1, 16'hA5A0});
    at_rel(65);
    chk_both("t1_wr0_off", 5, 0);
    at_rel(131);
    chk_both("t1_wr1", 5, 5'h1F);
    chk_both("t1_data1", 6, {16'hB5A4, 16'hB5A3, 16'hB5A2, 16'hB5A1, 16'hB5A0});
    at_rel(134);
    chk_both("t1_compl", 1, 1);
    chk_both("t1_busy_end", 0, 0);
    at_rel(135);
    chk_both("t1_compl_off", 1, 0);

    // Narrow pulse shape div=5 duty=1
    start_burst(16'd2, 16'd5, 16'd1, 16'hA5A0, 1'b0);
    at_rel(79);
    chk_both("t2_cs_last", 3, 0);
    at_rel(80);
    chk_both("t2_wr0", 5, 5'h1F);
    chk_both("t2_cs_gap", 3, 1);
    chk_both("t2_data0", 6, {16'hA5A4, 16'hA5A3, 16'hA5A2, 16'hA5A1, 16'hA5A0});
    at_rel(166);
    chk_both("t2_compl", 1, 1);
    at_rel(168);

    // One FIFO full during the write
    start_burst(16'd1, 16'd4, 16'd2, 16'h5A00, 1'b0);
    at_rel(60);
    full = 5'b00100;
    at_rel(64);
    chk_both("t3_wr", 5, 5'b11011);
    chk_both("t3_err", 2, 1);
    chk_both("t3_data", 6, {16'h5A04, 16'h5A03, 16'h5A02, 16'h5A01, 16'h5A00});
    at_rel(66);
    full = '0;
    at_rel(67);
    chk_both("t3_compl", 1, 1);
    at_rel(75);
    chk_both("t3_err_sticky", 2, 1);

    // Zero-length burst; its accepting edge also clears the error
    start_burst(16'd0, 16'd4, 16'd2, 16'h0000, 1'b0);
    chk_both("t4_compl", 1, 1);
    chk_both("t4_busy", 0, 0);
    chk_both("t4_cs", 3, 1);
    chk_both("t4_err_clr", 2, 0);
    at_rel(1);
    chk_both("t4_compl_off", 1, 0);
    at_rel(4);

    // Enable dropped during word 3 with start held high
    snap = wrcnt;
    start_burst(16'd10, 16'd4, 16'd2, 16'h0F00, 1'b1);
    at_rel(210);
    en = 1'b0;
    at_rel(268);
    chk_both("t5_compl", 1, 1);
    at_rel(280);
    chk_both("t5_idle_busy", 0, 0);
    chk_both("t5_idle_cs", 3, 1);
    chk("t5_writes", 128'(wrcnt - snap), 128'(4));
    en = 1'b1;
    @(negedge clk);
    rel = 0;
    chk_both("t5_rearm_busy", 0, 1);
    chk_both("t5_rearm_cs", 3, 0);
    start = 1'b0;
    at_rel(5);
    en = 1'b0;
    at_rel(67);
    chk_both("t5b_compl", 1, 1);
    at_rel(69);
    en = 1'b1;

    // Reset mid-burst, then a clean burst
    snap = wrcnt;
    start_burst(16'd2, 16'd4, 16'd2, 16'h3C00, 1'b0);
    at_rel(20);
    rst = 1'b1;
    at_rel(21);
    chk_reset_state("t6_rst");
    rst = 1'b0;
    at_rel(30);
    chk("t6_no_write", 128'(wrcnt - snap), 128'(0));
    chk_both("t6_no_compl", 1, 0);
    start_burst(16'd1, 16'd4, 16'd2, 16'h1234, 1'b0);
    at_rel(64);
    chk_both("t6_wr", 5, 5'h1F);
    chk_both("t6_data", 6, {16'h1238, 16'h1237, 16'h1236, 16'h1235, 16'h1234});
    at_rel(67);
    chk_both("t6_compl", 1, 1);
    at_rel(70);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
